// File: rtl/bullet_arbiter.sv
// bullet_arbiter
//   Shares one bullet-flight timer between two tanks. Arbitrates fire
//   requests, drives the per-player draw flags, sequences each shot through
//   launch, flight, termination and cooldown, and counts flight ticks.
//   Clocked once per video frame.
//
// Ports
//   frame_clk      frame-rate clock
//   Reset          synchronous, active-high reset
//   fire1, fire2   player fire requests (level, sampled only while idle)
//   hit            active bullet struck a target
//   xbound         active bullet left the screen
//   drawbullflag   player 1 bullet active
//   drawbullflag2  player 2 bullet active
//   bull_time      flight ticks since launch
//   busy           shot or cooldown in progress
//   done           one-cycle pulse on shot termination
//   result         termination cause with done: 01 hit, 10 xbound, 11 timeout
//   done_owner     owner of the terminated shot: 0 player 1, 1 player 2
module bullet_arbiter #(
  parameter int STEP_DIV  = 3,
  parameter int MAX_TICKS = 200,
  parameter int COOLDOWN  = 30,
  parameter int TW        = 16
) (
  input  logic          frame_clk,
  input  logic          Reset,
  input  logic          fire1,
  input  logic          fire2,
  input  logic          hit,
  input  logic          xbound,
  output logic          drawbullflag,
  output logic          drawbullflag2,
  output logic [TW-1:0] bull_time,
  output logic          busy,
  output logic          done,
  output logic [1:0]    result,
  output logic          done_owner
);

  localparam int DW      = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int CW      = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
  localparam int CD_LOAD = (COOLDOWN > 0) ? COOLDOWN - 1 : 0;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_FLIGHT   = 2'd1,
    S_COOLDOWN = 2'd2
  } state_t;

  state_t          state_q;
  logic            flag1_q;
  logic            flag2_q;
  logic [TW-1:0]   bull_time_q;
  logic [DW-1:0]   div_q;
  logic [CW-1:0]   cd_q;
  logic            busy_q;
  logic            done_q;
  logic [1:0]      result_q;
  logic            owner_q;
  logic            last_grant_q;   // 0 = player 1, 1 = player 2

  logic            grant_vld_d;
  logic            grant_p2_d;
  logic            term_d;
  logic [1:0]      cause_d;

  // Grant and termination decisions on the current-cycle inputs. A tie goes
  // to whichever player did not win the previous grant.
  always_comb begin
    grant_vld_d = fire1 | fire2;
    grant_p2_d  = (fire1 && fire2) ? ~last_grant_q : fire2;
    term_d      = 1'b0;
    cause_d     = 2'b00;
    if (hit) begin
      term_d  = 1'b1;
      cause_d = 2'b01;
    end else if (xbound) begin
      term_d  = 1'b1;
      cause_d = 2'b10;
    end else if (bull_time_q == TW'(MAX_TICKS)) begin
      term_d  = 1'b1;
      cause_d = 2'b11;
    end
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state_q      <= S_IDLE;
      flag1_q      <= 1'b0;
      flag2_q      <= 1'b0;
      bull_time_q  <= '0;
      div_q        <= '0;
      cd_q         <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      result_q     <= 2'b00;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (grant_vld_d) begin
            state_q      <= S_FLIGHT;
            busy_q       <= 1'b1;
            flag1_q      <= ~grant_p2_d;
            flag2_q      <= grant_p2_d;
            bull_time_q  <= '0;
            div_q        <= '0;
            last_grant_q <= grant_p2_d;
          end
        end
        S_FLIGHT: begin
          if (term_d) begin
            flag1_q     <= 1'b0;
            flag2_q     <= 1'b0;
            done_q      <= 1'b1;
            result_q    <= cause_d;
            owner_q     <= flag2_q;
            bull_time_q <= '0;
            if (COOLDOWN == 0) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= S_COOLDOWN;
              cd_q    <= CW'(CD_LOAD);
            end
          end else if (div_q == DW'(STEP_DIV - 1)) begin
            div_q <= '0;
            // Saturate so the count can never pass the timeout value.
            if (bull_time_q < TW'(MAX_TICKS))
              bull_time_q <= bull_time_q + TW'(1);
          end else begin
            div_q <= div_q + DW'(1);
          end
        end
        S_COOLDOWN: begin
          if (cd_q == '0) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            cd_q <= cd_q - CW'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          flag1_q <= 1'b0;
          flag2_q <= 1'b0;
        end
      endcase
    end
  end

  assign drawbullflag  = flag1_q;
  assign drawbullflag2 = flag2_q;
  assign bull_time     = bull_time_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign result        = result_q;
  assign done_owner    = owner_q;

endmodule

// File: tb/tb_bullet_arbiter.sv
// Testbench for bullet_arbiter: default-parameter instance plus a
// COOLDOWN = 0 instance. Expected termination events are queued when the
// terminating stimulus is driven and compared against observed done pulses.
module tb_bullet_arbiter;

  logic        frame_clk = 1'b0;
  logic        Reset = 1'b1;
  logic        fire1 = 1'b0, fire2 = 1'b0, hit = 1'b0, xbound = 1'b0;
  logic        drawbullflag, drawbullflag2, busy, done, done_owner;
  logic [15:0] bull_time;
  logic [1:0]  result;

  logic        fire1_b = 1'b0, fire2_b = 1'b0, hit_b = 1'b0, xbound_b = 1'b0;
  logic        flag1_b, flag2_b, busy_b, done_b, owner_b;
  logic [15:0] bull_time_b;
  logic [1:0]  result_b;

  int tests = 0;
  int fails = 0;

  logic [2:0] exp_q[$], obs_q[$], exp_b[$], obs_b[$];

  bullet_arbiter u_dut (
    .frame_clk(frame_clk), .Reset(Reset), .fire1(fire1), .fire2(fire2),
    .hit(hit), .xbound(xbound), .drawbullflag(drawbullflag),
    .drawbullflag2(drawbullflag2), .bull_time(bull_time), .busy(busy),
    .done(done), .result(result), .done_owner(done_owner)
  );

  bullet_arbiter #(.COOLDOWN(0)) u_dut0 (
    .frame_clk(frame_clk), .Reset(Reset), .fire1(fire1_b), .fire2(fire2_b),
    .hit(hit_b), .xbound(xbound_b), .drawbullflag(flag1_b),
    .drawbullflag2(flag2_b), .bull_time(bull_time_b), .busy(busy_b),
    .done(done_b), .result(result_b), .done_owner(owner_b)
  );

  always #5 frame_clk = ~frame_clk;

  // One frame: advance past the active edge, then record any done pulse.
  task automatic tick();
    @(posedge frame_clk);
    #1;
    if (done === 1'b1)   obs_q.push_back({result, done_owner});
    if (done_b === 1'b1) obs_b.push_back({result_b, owner_b});
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_idle(input int budget, input string nm);
    int k = 0;
    while (busy === 1'b1 && k < budget) begin tick(); k++; end
    tests++;
    if (busy !== 1'b0) begin
      fails++; $display("FAIL %s_idle_timeout busy got %b want 0", nm, busy);
    end
  endtask

  // Scoreboard drain: expected vs observed termination events.
  task automatic drain(input string nm);
    logic [2:0] e, o;
    tests++;
    if (obs_q.size() != exp_q.size()) begin
      fails++; $display("FAIL %s_done_count got %0d want %0d", nm, obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
      if (o !== e) begin fails++; $display("FAIL %s_done_event got %b want %b", nm, o, e); end
    end
    tests++;
    if (obs_b.size() != exp_b.size()) begin
      fails++; $display("FAIL %s_done_count_b got %0d want %0d", nm, obs_b.size(), exp_b.size());
    end
    while (exp_b.size() > 0 && obs_b.size() > 0) begin
      e = exp_b.pop_front(); o = obs_b.pop_front(); tests++;
      if (o !== e) begin fails++; $display("FAIL %s_done_event_b got %b want %b", nm, o, e); end
    end
    exp_q.delete(); obs_q.delete(); exp_b.delete(); obs_b.delete();
  endtask

  task automatic test_reset();
    Reset = 1'b1; tick(); Reset = 1'b0;
    tests++;
    if ({drawbullflag, drawbullflag2, busy, done, result, done_owner} !== 7'b0 || bull_time !== 16'd0) begin
      fails++; $display("FAIL reset_outputs got %b/%0d want 0", {drawbullflag, drawbullflag2, busy, done, result, done_owner}, bull_time);
    end
    tests++;
    if ({flag1_b, flag2_b, busy_b, done_b} !== 4'b0) begin
      fails++; $display("FAIL reset_outputs_b got %b want 0000", {flag1_b, flag2_b, busy_b, done_b});
    end
    drain("reset");
  endtask

  task automatic test_fire1_hit();
    fire1 = 1'b1; tick(); fire1 = 1'b0;
    tests++;
    if ({drawbullflag, drawbullflag2, busy} !== 3'b101 || bull_time !== 16'd0) begin
      fails++; $display("FAIL launch1 flags/busy got %b bt %0d want 101 bt 0", {drawbullflag, drawbullflag2, busy}, bull_time);
    end
    ticks(3);
    tests++;
    if (bull_time !== 16'd1) begin fails++; $display("FAIL bt_after3 got %0d want 1", bull_time); end
    ticks(3);
    tests++;
    if (bull_time !== 16'd2) begin fails++; $display("FAIL bt_after6 got %0d want 2", bull_time); end
    hit = 1'b1; xbound = 1'b1; exp_q.push_back({2'b01, 1'b0});
    tick(); hit = 1'b0; xbound = 1'b0;
    tests++;
    if ({done, drawbullflag, drawbullflag2, busy} !== 4'b1001 || bull_time !== 16'd0) begin
      fails++; $display("FAIL term_hit done/f1/f2/busy got %b bt %0d want 1001 bt 0", {done, drawbullflag, drawbullflag2, busy}, bull_time);
    end
    ticks(29);
    tests++;
    if ({busy, done} !== 2'b10) begin fails++; $display("FAIL cooldown_29 busy/done got %b want 10", {busy, done}); end
    tick();
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL cooldown_30 busy got %b want 0", busy); end
    drain("fire1_hit");
  endtask

  task automatic test_tie();
    Reset = 1'b1; tick(); Reset = 1'b0;
    fire1 = 1'b1; fire2 = 1'b1; tick(); fire1 = 1'b0; fire2 = 1'b0;
    tests++;
    if ({drawbullflag, drawbullflag2} !== 2'b10) begin fails++; $display("FAIL tie1 flags got %b want 10", {drawbullflag, drawbullflag2}); end
    xbound = 1'b1; exp_q.push_back({2'b10, 1'b0}); tick(); xbound = 1'b0;
    wait_idle(40, "tie1");
    fire1 = 1'b1; fire2 = 1'b1; tick(); fire1 = 1'b0; fire2 = 1'b0;
    tests++;
    if ({drawbullflag, drawbullflag2} !== 2'b01) begin fails++; $display("FAIL tie2 flags got %b want 01", {drawbullflag, drawbullflag2}); end
    xbound = 1'b1; exp_q.push_back({2'b10, 1'b1}); tick(); xbound = 1'b0;
    wait_idle(40, "tie2");
    fire1 = 1'b1; fire2 = 1'b1; tick(); fire1 = 1'b0; fire2 = 1'b0;
    tests++;
    if ({drawbullflag, drawbullflag2} !== 2'b10) begin fails++; $display("FAIL tie3 flags got %b want 10", {drawbullflag, drawbullflag2}); end
    hit = 1'b1; exp_q.push_back({2'b01, 1'b0}); tick(); hit = 1'b0;
    wait_idle(40, "tie3");
    drain("tie");
  endtask

  task automatic test_timeout();
    int k = 0;
    int maxbt = 0;
    fire2 = 1'b1; tick(); fire2 = 1'b0;
    exp_q.push_back({2'b11, 1'b1});
    while (done !== 1'b1 && k < 700) begin
      if (int'(bull_time) > maxbt) maxbt = int'(bull_time);
      tick(); k++;
    end
    tests++;
    if (k !== 601) begin fails++; $display("FAIL timeout_frames got %0d want 601", k); end
    tests++;
    if (maxbt !== 200) begin fails++; $display("FAIL timeout_max_bt got %0d want 200", maxbt); end
    wait_idle(40, "timeout");
    drain("timeout");
  endtask

  task automatic test_ignore();
    fire1 = 1'b1; tick(); fire1 = 1'b0;
    fire2 = 1'b1; tick(); fire2 = 1'b0;
    tests++;
    if ({drawbullflag, drawbullflag2} !== 2'b10) begin fails++; $display("FAIL flight_fire2 flags got %b want 10", {drawbullflag, drawbullflag2}); end
    hit = 1'b1; exp_q.push_back({2'b01, 1'b0}); tick(); hit = 1'b0;
    ticks(5); fire2 = 1'b1; tick(); fire2 = 1'b0;
    wait_idle(40, "ignore_pulse");
    ticks(2);
    tests++;
    if ({busy, drawbullflag, drawbullflag2} !== 3'b000) begin fails++; $display("FAIL no_queued_grant got %b want 000", {busy, drawbullflag, drawbullflag2}); end
    fire1 = 1'b1; tick(); fire1 = 1'b0;
    hit = 1'b1; exp_q.push_back({2'b01, 1'b0}); tick(); hit = 1'b0;
    fire2 = 1'b1;
    wait_idle(40, "hold_fire2");
    tests++;
    if (drawbullflag2 !== 1'b0) begin fails++; $display("FAIL hold_fire2_early got %b want 0", drawbullflag2); end
    tick(); fire2 = 1'b0;
    tests++;
    if ({busy, drawbullflag2} !== 2'b11) begin fails++; $display("FAIL hold_fire2_grant busy/f2 got %b want 11", {busy, drawbullflag2}); end
    xbound = 1'b1; exp_q.push_back({2'b10, 1'b1}); tick(); xbound = 1'b0;
    wait_idle(40, "ignore_end");
    drain("ignore");
  endtask

  task automatic test_reset_midflight();
    int k = 0;
    fire1 = 1'b1; tick(); fire1 = 1'b0;
    while (bull_time !== 16'd50 && k < 200) begin tick(); k++; end
    tests++;
    if (bull_time !== 16'd50) begin fails++; $display("FAIL mid_bt got %0d want 50", bull_time); end
    Reset = 1'b1; tick(); Reset = 1'b0;
    tests++;
    if ({drawbullflag, drawbullflag2, busy, done, result, done_owner} !== 7'b0 || bull_time !== 16'd0) begin
      fails++; $display("FAIL mid_reset got %b/%0d want 0", {drawbullflag, drawbullflag2, busy, done, result, done_owner}, bull_time);
    end
    tick();
    tests++;
    if ({busy, done} !== 2'b00) begin fails++; $display("FAIL mid_reset_after got %b want 00", {busy, done}); end
    drain("reset_mid");
  endtask

  task automatic test_cooldown0();
    fire1_b = 1'b1; tick();
    tests++;
    if ({flag1_b, busy_b} !== 2'b11) begin fails++; $display("FAIL cd0_launch got %b want 11", {flag1_b, busy_b}); end
    hit_b = 1'b1; exp_b.push_back({2'b01, 1'b0}); tick(); hit_b = 1'b0;
    tests++;
    if ({done_b, busy_b, flag1_b} !== 3'b100) begin fails++; $display("FAIL cd0_term done/busy/f1 got %b want 100", {done_b, busy_b, flag1_b}); end
    tick(); fire1_b = 1'b0;
    tests++;
    if ({done_b, busy_b, flag1_b} !== 3'b011) begin fails++; $display("FAIL cd0_relaunch done/busy/f1 got %b want 011", {done_b, busy_b, flag1_b}); end
    xbound_b = 1'b1; exp_b.push_back({2'b10, 1'b0}); tick(); xbound_b = 1'b0;
    tests++;
    if (busy_b !== 1'b0) begin fails++; $display("FAIL cd0_end busy got %b want 0", busy_b); end
    drain("cooldown0");
  endtask

  initial begin
    test_reset();
    test_fire1_hit();
    test_tie();
    test_timeout();
    test_ignore();
    test_reset_midflight();
    test_cooldown0();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
